// File: rtl/text_console_ctrl.sv
// Console byte-stream front end for the text display: interprets control codes, tracks the cursor,
// and sequences character / clear-screen / line-clear writes into the character buffer.
module text_console_ctrl #(
    parameter int         COLS = 160,
    parameter int         ROWS = 64,
    parameter int         TABW = 8,
    parameter logic [7:0] FILL = 8'h20
) (
    input  logic        busclk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  cursor_x,
    output logic [5:0]  cursor_y,
    output logic        busy,
    output logic [14:0] waddr,
    output logic [7:0]  wdata,
    output logic        wr_en
);

    localparam logic [7:0] LAST_COL = 8'(COLS - 1);
    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);
    localparam logic [8:0] TAB_MASK = 9'(TABW - 1);
    localparam logic [8:0] COLS_W   = 9'(COLS);

    typedef enum logic [1:0] {
        S_CLEAR   = 2'd0,
        S_IDLE    = 2'd1,
        S_LINECLR = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [13:0] r_cnt;
    logic [7:0]  r_x;
    logic [5:0]  r_y;

    logic        w_accept;
    logic        w_is_lf;
    logic        w_is_cr;
    logic        w_is_bs;
    logic        w_is_tab;
    logic        w_is_ff;
    logic        w_is_print;
    logic [8:0]  w_tab_x;
    logic        w_tab_wrap;
    logic [5:0]  w_y_adv;
    logic        w_row_adv;

    assign cursor_x = r_x;
    assign cursor_y = r_y;

    always_comb begin
        w_accept   = in_valid && (r_state == S_IDLE);
        w_is_lf    = (in_data == 8'h0A);
        w_is_cr    = (in_data == 8'h0D);
        w_is_bs    = (in_data == 8'h08);
        w_is_tab   = (in_data == 8'h09);
        w_is_ff    = (in_data == 8'h0C);
        w_is_print = (in_data >= 8'h20) && (in_data != 8'h7F);
        // 9-bit so a tab from column 255 can still be seen to overflow
        w_tab_x    = ({1'b0, r_x} | TAB_MASK) + 9'd1;
        w_tab_wrap = (w_tab_x >= COLS_W);
        w_y_adv    = (r_y == LAST_ROW) ? 6'd0 : r_y + 6'd1;
        w_row_adv  = w_accept && (w_is_lf
                                  || (w_is_print && (r_x == LAST_COL))
                                  || (w_is_tab && w_tab_wrap));
    end

    // State register
    always_ff @(posedge busclk) begin
        if (rst) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: begin
                if (r_cnt == 14'h3FFF) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (w_accept && w_is_ff) begin
                    w_state_nxt = S_CLEAR;
                end else if (w_row_adv) begin
                    w_state_nxt = S_LINECLR;
                end
            end
            S_LINECLR: begin
                if (r_cnt[7:0] == LAST_COL) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // Handshake / status outputs
    always_comb begin
        in_ready = (r_state == S_IDLE);
        busy     = (r_state != S_IDLE);
    end

    // Cursor, sweep counter and registered write port
    always_ff @(posedge busclk) begin
        if (rst) begin
            r_cnt <= 14'd0;
            r_x   <= 8'd0;
            r_y   <= 6'd0;
            wr_en <= 1'b0;
            waddr <= 15'd0;
            wdata <= 8'd0;
        end else begin
            wr_en <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    wr_en <= 1'b1;
                    waddr <= {1'b0, r_cnt};
                    wdata <= FILL;
                    r_cnt <= r_cnt + 14'd1;
                end
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= 14'd0;
                        if (w_is_ff) begin
                            r_x <= 8'd0;
                            r_y <= 6'd0;
                        end else if (w_is_lf) begin
                            r_x <= 8'd0;
                            r_y <= w_y_adv;
                        end else if (w_is_cr) begin
                            r_x <= 8'd0;
                        end else if (w_is_bs) begin
                            if (r_x != 8'd0) begin
                                r_x   <= r_x - 8'd1;
                                wr_en <= 1'b1;
                                waddr <= {1'b0, r_y, r_x - 8'd1};
                                wdata <= FILL;
                            end
                        end else if (w_is_tab) begin
                            if (w_tab_wrap) begin
                                r_x <= 8'd0;
                                r_y <= w_y_adv;
                            end else begin
                                r_x <= w_tab_x[7:0];
                            end
                        end else if (w_is_print) begin
                            wr_en <= 1'b1;
                            waddr <= {1'b0, r_y, r_x};
                            wdata <= in_data;
                            if (r_x == LAST_COL) begin
                                r_x <= 8'd0;
                                r_y <= w_y_adv;
                            end else begin
                                r_x <= r_x + 8'd1;
                            end
                        end
                    end
                end
                S_LINECLR: begin
                    // r_y already holds the new row; sweep its columns
                    wr_en <= 1'b1;
                    waddr <= {1'b0, r_y, r_cnt[7:0]};
                    wdata <= FILL;
                    r_cnt <= r_cnt + 14'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Bench for text_console_ctrl: directed vectors, corner sequences and random bytes vs a cursor/write model.
module tb_text_console_ctrl;

    localparam int         COLS = 160;
    localparam int         ROWS = 64;
    localparam int         TABW = 8;
    localparam logic [7:0] FILL = 8'h20;

    logic        busclk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  cursor_x;
    logic [5:0]  cursor_y;
    logic        busy;
    logic [14:0] waddr;
    logic [7:0]  wdata;
    logic        wr_en;

    text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .TABW(TABW), .FILL(FILL)) dut (
        .busclk   (busclk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y),
        .busy     (busy),
        .waddr    (waddr),
        .wdata    (wdata),
        .wr_en    (wr_en)
    );

    always #5 busclk = ~busclk;

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int         sx;
        int         sy;
        logic [7:0] b;
        int         ex;
        int         ey;
        int         nw;
        int         a0;
        int         d0;
        int         stall;
    } vec_t;

    wr_t  obs_q[$];
    wr_t  exp_q[$];
    vec_t vecs[16];
    int   cyc_n  = 0;
    int   checks = 0;
    int   errors = 0;
    int   mx;
    int   my;

    always @(posedge busclk) cyc_n++;

    always @(negedge busclk) begin
        if (wr_en === 1'b1) obs_q.push_back(wr_t'{cyc: cyc_n, addr: int'(waddr), data: int'(wdata)});
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // Reference model: cursor as plain integers, expected writes as an ordered list
    task automatic push_exp(input int addr, input int data);
        exp_q.push_back(wr_t'{cyc: 0, addr: addr, data: data});
    endtask

    task automatic advance_row();
        my = (my + 1) % ROWS;
        for (int c = 0; c < COLS; c++) push_exp(my * 256 + c, FILL);
    endtask

    task automatic model_byte(input logic [7:0] b);
        int t;
        if (b == 8'h0A) begin
            mx = 0;
            advance_row();
        end else if (b == 8'h0D) begin
            mx = 0;
        end else if (b == 8'h08) begin
            if (mx > 0) begin
                mx = mx - 1;
                push_exp(my * 256 + mx, FILL);
            end
        end else if (b == 8'h09) begin
            t = (mx / TABW + 1) * TABW;
            if (t >= COLS) begin
                mx = 0;
                advance_row();
            end else begin
                mx = t;
            end
        end else if (b >= 8'h20 && b != 8'h7F) begin
            push_exp(my * 256 + mx, int'(b));
            if (mx < COLS - 1) begin
                mx = mx + 1;
            end else begin
                mx = 0;
                advance_row();
            end
        end
    endtask

    // Hold in_valid until the controller is ready; returns just after the accepting edge
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge busclk);
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 20000) begin
            @(negedge busclk);
            n++;
        end
        if (n >= 20000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready never rose for byte 0x%0h", b);
        end
        @(posedge busclk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int stall);
        stall = 0;
        @(negedge busclk);
        while (in_ready !== 1'b1 && stall < 40000) begin
            stall++;
            @(negedge busclk);
        end
        if (stall >= 40000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: in_ready stayed low for %0d cycles", stall);
        end
        #1;
    endtask

    task automatic cmp_writes(input string name);
        int bad;
        int first;
        int n_obs;
        int n_exp;
        n_obs = obs_q.size();
        n_exp = exp_q.size();
        bad   = 0;
        first = -1;
        for (int i = 0; i < n_obs && i < n_exp; i++) begin
            if (obs_q[i].addr != exp_q[i].addr || obs_q[i].data != exp_q[i].data) begin
                if (first < 0) first = i;
                bad++;
            end
        end
        checks++;
        if (bad != 0 || n_obs != n_exp) begin
            errors++;
            if (first >= 0)
                $display("FAIL %s: %0d writes seen vs %0d expected, %0d differ, first at %0d got %04h=%02h expected %04h=%02h",
                         name, n_obs, n_exp, bad, first, obs_q[first].addr, obs_q[first].data,
                         exp_q[first].addr, exp_q[first].data);
            else
                $display("FAIL %s: %0d writes seen vs %0d expected", name, n_obs, n_exp);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_sweep(input string name);
        exp_q.delete();
        for (int a = 0; a < 16384; a++) push_exp(a, FILL);
        cmp_writes(name);
    endtask

    task automatic goto_xy(input int tx, input int ty);
        int st;
        send(8'h0D);
        model_byte(8'h0D);
        while (my != ty) begin
            send(8'h0A);
            model_byte(8'h0A);
        end
        repeat (tx) begin
            send(8'h20);
            model_byte(8'h20);
        end
        wait_idle(st);
        cmp_writes("goto_writes");
    endtask

    initial begin
        int         st;
        int         bad;
        int         r;
        logic [7:0] b;
        vec_t       v;

        //            sx   sy  byte    ex  ey  nw   a0       d0     stall
        vecs[0]  = '{  5, 63, 8'h0A,   0,  0, 160, 'h0000, 'h20, 160};
        vecs[1]  = '{159,  2, 8'h5A,   0,  3, 161, 'h029F, 'h5A, 160};
        vecs[2]  = '{  0,  3, 8'h08,   0,  3,   0, 0,      0,    0};
        vecs[3]  = '{  3,  3, 8'h08,   2,  3,   1, 'h0302, 'h20, 0};
        vecs[4]  = '{157,  3, 8'h09,   0,  4, 160, 'h0400, 'h20, 160};
        vecs[5]  = '{ 10,  4, 8'h09,  16,  4,   0, 0,      0,    0};
        vecs[6]  = '{ 16,  4, 8'h09,  24,  4,   0, 0,      0,    0};
        vecs[7]  = '{ 20,  4, 8'h0D,   0,  4,   0, 0,      0,    0};
        vecs[8]  = '{  7,  4, 8'h7F,   7,  4,   0, 0,      0,    0};
        vecs[9]  = '{  7,  4, 8'h1B,   7,  4,   0, 0,      0,    0};
        vecs[10] = '{  7,  4, 8'hE9,   8,  4,   1, 'h0407, 'hE9, 0};
        vecs[11] = '{152,  4, 8'h09,   0,  5, 160, 'h0500, 'h20, 160};
        vecs[12] = '{  9,  5, 8'h7E,  10,  5,   1, 'h0509, 'h7E, 0};
        vecs[13] = '{  9,  5, 8'h20,  10,  5,   1, 'h0509, 'h20, 0};
        vecs[14] = '{158,  5, 8'h41, 159,  5,   1, 'h059E, 'h41, 0};
        vecs[15] = '{  0,  6, 8'h0D,   0,  6,   0, 0,      0,    0};

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge busclk);
        chk("reset_wr_en", wr_en, 0);
        chk("reset_busy", busy, 1);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_cursor_x", cursor_x, 0);
        chk("reset_cursor_y", cursor_y, 0);
        rst = 1'b0;
        obs_q.delete();
        exp_q.delete();

        wait_idle(st);
        check_sweep("init_sweep");
        chk("init_cursor_x", cursor_x, 0);
        chk("init_cursor_y", cursor_y, 0);
        chk("init_busy", busy, 0);
        mx = 0;
        my = 0;

        // Back-to-back printable bytes
        send(8'h41);
        send(8'h42);
        wait_idle(st);
        chk("ab_write_count", obs_q.size(), 2);
        if (obs_q.size() == 2) chk("ab_consecutive", obs_q[1].cyc - obs_q[0].cyc, 1);
        model_byte(8'h41);
        model_byte(8'h42);
        cmp_writes("ab_writes");
        chk("ab_cursor_x", cursor_x, 2);

        for (int i = 0; i < 16; i++) begin
            v = vecs[i];
            goto_xy(v.sx, v.sy);
            send(v.b);
            chk($sformatf("vec%0d_cursor_x", i), cursor_x, v.ex);
            chk($sformatf("vec%0d_cursor_y", i), cursor_y, v.ey);
            wait_idle(st);
            chk($sformatf("vec%0d_stall", i), st, v.stall);
            chk($sformatf("vec%0d_nwrites", i), obs_q.size(), v.nw);
            if (v.nw > 0 && obs_q.size() > 0) begin
                chk($sformatf("vec%0d_addr0", i), obs_q[0].addr, v.a0);
                chk($sformatf("vec%0d_data0", i), obs_q[0].data, v.d0);
            end
            model_byte(v.b);
            cmp_writes($sformatf("vec%0d_writes", i));
        end

        // Random byte stream (form feed excluded; it has its own sequence)
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge busclk);
            r = $urandom_range(0, 99);
            if (r < 60) begin
                b = 8'($urandom_range(32, 255));
                if (b == 8'h7F) b = 8'h41;
            end else if (r < 66) b = 8'h0A;
            else if (r < 72) b = 8'h0D;
            else if (r < 80) b = 8'h08;
            else if (r < 90) b = 8'h09;
            else if (r < 95) b = 8'h7F;
            else begin
                b = 8'($urandom_range(0, 31));
                if (b == 8'h0C) b = 8'h01;
            end
            send(b);
            model_byte(b);
            chk($sformatf("rand%0d_cursor_x", i), cursor_x, mx);
            chk($sformatf("rand%0d_cursor_y", i), cursor_y, my);
        end
        wait_idle(st);
        cmp_writes("random_writes");

        // Form feed, then reset partway into its clear sweep
        send(8'h0C);
        chk("ff_cursor_x", cursor_x, 0);
        chk("ff_cursor_y", cursor_y, 0);
        chk("ff_busy", busy, 1);
        chk("ff_in_ready", in_ready, 0);
        repeat (100) @(negedge busclk);
        #1;
        bad = 0;
        foreach (obs_q[i]) if (obs_q[i].addr != i || obs_q[i].data != FILL) bad++;
        chk("ff_partial_order", bad, 0);
        chk("ff_partial_progress", (obs_q.size() >= 98 && obs_q.size() <= 100), 1);
        rst = 1'b1;
        @(negedge busclk);
        #1;
        chk("rst_mid_wr_en", wr_en, 0);
        chk("rst_mid_busy", busy, 1);
        chk("rst_mid_cursor_x", cursor_x, 0);
        chk("rst_mid_cursor_y", cursor_y, 0);
        rst = 1'b0;
        obs_q.delete();
        exp_q.delete();
        wait_idle(st);
        check_sweep("rst_mid_sweep");
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_final_x", cursor_x, 0);
        chk("rst_mid_final_y", cursor_y, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
